// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Holds funct3 encodings, FSM state and size enums, and the latched request record.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 9;
  localparam int DMEM_DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } dmem_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } dmem_size_t;

  typedef struct packed {
    logic                   we;
    logic [2:0]             funct3;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

  // Stores only know SB/SH/SW and loads only B/H/W/BU/HU; anything else is a full word.
  function automatic dmem_size_t access_size(input logic we, input logic [2:0] funct3);
    dmem_size_t size;
    size = SZ_W;
    if (we) begin
      case (funct3)
        F3_B:    size = SZ_B;
        F3_H:    size = SZ_H;
        default: size = SZ_W;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: size = SZ_B;
        F3_H, F3_HU: size = SZ_H;
        default:     size = SZ_W;
      endcase
    end
    return size;
  endfunction

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Combinational byte-lane steering for one data-memory access.
// Produces write enables, lane-replicated store data, extended load data and a misalign flag.
module dmem_lane_ctrl
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wr,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  dmem_size_t  size;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_unsigned;

  always_comb begin
    size        = access_size(we, funct3);
    is_unsigned = funct3[2];
  end

  always_comb begin
    misalign = 1'b0;
    case (size)
      SZ_H:    misalign = off[0];
      SZ_W:    misalign = |off;
      default: misalign = 1'b0;
    endcase
  end

  // Replicating the store data means every lane the enable picks already holds the right bytes.
  always_comb begin
    wr       = 4'b0000;
    wdata_sh = wdata;
    case (size)
      SZ_B:    wdata_sh = {4{wdata[7:0]}};
      SZ_H:    wdata_sh = {2{wdata[15:0]}};
      default: wdata_sh = wdata;
    endcase
    if (we && !misalign) begin
      case (size)
        SZ_B:    wr = 4'b0001 << off;
        SZ_H:    wr = 4'b0011 << off;
        default: wr = 4'b1111;
      endcase
    end
  end

  always_comb begin
    byte_sel  = rdata[{off, 3'b000} +: 8];
    half_sel  = rdata[{off[1], 4'b0000} +: 16];
    rdata_ext = rdata;
    case (size)
      SZ_B:    rdata_ext = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    rdata_ext = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter and 3-state access sequencer in front of the negedge-clocked word data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0]                 req_we,
  input  logic [1:0][2:0]            req_funct3,
  input  logic [1:0][DM_ADDRESS-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0]     req_wdata,
  output logic [1:0]                 rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic [DM_ADDRESS-1:0]      mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [3:0]                 mem_wr,
  input  logic [DATA_W-1:0]          mem_rdata
);

  dmem_state_t state;
  dmem_req_t   lat;
  logic        lat_id;
  logic        gnt;

  logic [3:0]        lane_wr;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_rdata;
  logic              lane_misalign;

`ifdef DMEM_ARB_RR_EN
  logic ptr;

  always_comb begin
    gnt = ptr ? req_valid[1] : ~req_valid[0];
  end
`else
  always_comb begin
    gnt = ~req_valid[0];
  end
`endif

  // Ready is suppressed under reset so a requester never sees a handshake the FSM then discards.
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && !rst && |req_valid) begin
      req_ready = gnt ? 2'b10 : 2'b01;
    end
  end

  dmem_lane_ctrl u_lane (
    .we        (lat.we),
    .funct3    (lat.funct3),
    .off       (lat.addr[1:0]),
    .wdata     (lat.wdata),
    .rdata     (mem_rdata),
    .wr        (lane_wr),
    .wdata_sh  (lane_wdata),
    .rdata_ext (lane_rdata),
    .misalign  (lane_misalign)
  );

  always_comb begin
    mem_addr  = {lat.addr[DM_ADDRESS-1:2], 2'b00};
    mem_wdata = lane_wdata;
    mem_wr    = (state == ACCESS) ? lane_wr : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat       <= '0;
      lat_id    <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      ptr       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 2'b00;
          if (|req_valid) begin
            lat.we     <= req_we[gnt];
            lat.funct3 <= req_funct3[gnt];
            lat.addr   <= req_addr[gnt];
            lat.wdata  <= req_wdata[gnt];
            lat_id     <= gnt;
            state      <= ACCESS;
`ifdef DMEM_ARB_RR_EN
            ptr        <= ~gnt;
`endif
          end
        end
        // mem_rdata already reflects the negedge read of this cycle's address.
        ACCESS: begin
          rsp_valid <= lat_id ? 2'b10 : 2'b01;
          rsp_rdata <= (lat.we || lane_misalign) ? '0 : lane_rdata;
          rsp_err   <= lane_misalign;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 2'b00;
          state     <= IDLE;
        end
        default: begin
          rsp_valid <= 2'b00;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a negedge-clocked word memory model.
// Build with +define+DMEM_ARB_RR_EN to expect round-robin grant order.
module tb_dmem_port_arbiter;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0][2:0]  req_funct3;
  logic [1:0][8:0]  req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic [8:0]       mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wr;
  logic [31:0]      mem_rdata;

  typedef struct {
    logic [1:0]  portOh;
    logic [31:0] rdata;
    logic        err;
  } rspExp_t;

  typedef struct {
    logic [3:0]  wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
  } accExp_t;

  rspExp_t rspQ[$];
  accExp_t accQ[$];

  int checkCount;
  int errorCount;
  bit accPending;

  logic [31:0] memArray [0:127];
  logic [31:0] memWord;

  dmem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: lane writes and the read both happen on the falling edge.
  initial begin
    for (int i = 0; i < 128; i++) memArray[i] = 32'h1000_0000 + i;
    mem_rdata = '0;
  end

  always @(negedge clk) begin
    memWord = memArray[mem_addr[8:2]];
    mem_rdata <= memArray[mem_addr[8:2]];
    for (int i = 0; i < 4; i++) begin
      if (mem_wr[i]) memWord[8*i +: 8] = mem_wdata[8*i +: 8];
    end
    memArray[mem_addr[8:2]] <= memWord;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: checks the memory-side cycle after each handshake and every response pulse.
  always @(negedge clk) begin
    if (accPending) begin
      if (accQ.size() == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL acc_unexpected got access expected none at %0t", $time);
      end else begin
        accExp_t a;
        a = accQ.pop_front();
        checkOutput("mem_wr", {28'd0, mem_wr}, {28'd0, a.wr});
        checkOutput("mem_addr", {23'd0, mem_addr}, {23'd0, a.addr});
        if (a.wr != 4'b0000) checkOutput("mem_wdata", mem_wdata, a.wdata);
      end
    end
    accPending = (|(req_valid & req_ready)) && !rst;
    if (|rsp_valid) begin
      if (rspQ.size() == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL rsp_unexpected got rsp_valid %b expected none at %0t", rsp_valid, $time);
      end else begin
        rspExp_t r;
        r = rspQ.pop_front();
        checkOutput("rsp_valid", {30'd0, rsp_valid}, {30'd0, r.portOh});
        checkOutput("rsp_rdata", rsp_rdata, r.rdata);
        checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
      end
    end
  end

  // Pushes the expected access and response, then holds the request until it is accepted.
  task automatic applyStimulus(input int p, input logic we, input logic [2:0] f3,
                               input logic [8:0] addr, input logic [31:0] wd,
                               input logic [3:0] expWr, input logic [31:0] expWdata,
                               input logic [31:0] expRdata, input logic expErr, input bit expectRsp);
    accExp_t a;
    rspExp_t r;
    int waited;
    a.wr = expWr;
    a.addr = {addr[8:2], 2'b00};
    a.wdata = expWdata;
    accQ.push_back(a);
    if (expectRsp) begin
      r.portOh = (p == 1) ? 2'b10 : 2'b01;
      r.rdata = expRdata;
      r.err = expErr;
      rspQ.push_back(r);
    end
    req_we[p] = we;
    req_funct3[p] = f3;
    req_addr[p] = addr;
    req_wdata[p] = wd;
    req_valid[p] = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (req_ready[p]) break;
      waited++;
      if (waited > 50) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL accept_timeout got no req_ready expected ready on port %0d", p);
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic pushGrant(input int p);
    accExp_t a;
    rspExp_t r;
    a.wr = 4'b0000;
    a.addr = (p == 1) ? 9'h020 : 9'h018;
    a.wdata = '0;
    accQ.push_back(a);
    r.portOh = (p == 1) ? 2'b10 : 2'b01;
    r.rdata = (p == 1) ? 32'h1000_0008 : 32'h1000_0006;
    r.err = 1'b0;
    rspQ.push_back(r);
  endtask

  initial begin
    int grants;
    int cycles;
    checkCount = 0;
    errorCount = 0;
    accPending = 0;
    rst = 1'b1;
    req_valid = '0;
    req_we = '0;
    req_funct3 = '0;
    req_addr = '0;
    req_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    checkOutput("reset_mem_wr", {28'd0, mem_wr}, 32'd0);
    checkOutput("reset_mem_addr", {23'd0, mem_addr}, 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    req_valid = 2'b01;
    #1;
    checkOutput("reset_req_ready", {30'd0, req_ready}, 32'd0);
    req_valid = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Word store and readback
    applyStimulus(0, 1'b1, 3'b010, 9'h010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 1);
    applyStimulus(0, 1'b0, 3'b010, 9'h010, 32'h0, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 1);

    // Byte store to the top lane, signed and unsigned byte loads
    applyStimulus(0, 1'b1, 3'b000, 9'h013, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0, 1);
    applyStimulus(0, 1'b0, 3'b000, 9'h013, 32'h0, 4'b0000, 32'h0, 32'hFFFF_FFA5, 1'b0, 1);
    applyStimulus(0, 1'b0, 3'b100, 9'h013, 32'h0, 4'b0000, 32'h0, 32'h0000_00A5, 1'b0, 1);

    // Misaligned half store must not touch memory
    applyStimulus(0, 1'b1, 3'b001, 9'h011, 32'h0000_1234, 4'b0000, 32'h0, 32'h0, 1'b1, 1);
    applyStimulus(0, 1'b0, 3'b010, 9'h010, 32'h0, 4'b0000, 32'h0, 32'hA5AD_BEEF, 1'b0, 1);

    // Upper half store and half/byte loads over the result
    applyStimulus(0, 1'b1, 3'b001, 9'h012, 32'h0000_8001, 4'b1100, 32'h8001_8001, 32'h0, 1'b0, 1);
    applyStimulus(0, 1'b0, 3'b001, 9'h012, 32'h0, 4'b0000, 32'h0, 32'hFFFF_8001, 1'b0, 1);
    applyStimulus(0, 1'b0, 3'b101, 9'h012, 32'h0, 4'b0000, 32'h0, 32'h0000_8001, 1'b0, 1);
    applyStimulus(1, 1'b0, 3'b000, 9'h011, 32'h0, 4'b0000, 32'h0, 32'hFFFF_FFBE, 1'b0, 1);
    applyStimulus(0, 1'b0, 3'b011, 9'h010, 32'h0, 4'b0000, 32'h0, 32'h8001_BEEF, 1'b0, 1);
    applyStimulus(0, 1'b0, 3'b010, 9'h012, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1);

    // Reset while a load is in its memory cycle: no response, then normal service
    applyStimulus(0, 1'b0, 3'b010, 9'h010, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    checkOutput("abort_req_ready", {30'd0, req_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(1, 1'b0, 3'b010, 9'h020, 32'h0, 4'b0000, 32'h0, 32'h1000_0008, 1'b0, 1);

    // Both ports requesting continuously for six grants
    for (int g = 0; g < 6; g++) begin
`ifdef DMEM_ARB_RR_EN
      pushGrant(g % 2);
`else
      pushGrant(0);
`endif
    end
    req_we = 2'b00;
    req_funct3[0] = 3'b010;
    req_funct3[1] = 3'b010;
    req_addr[0] = 9'h018;
    req_addr[1] = 9'h020;
    req_valid = 2'b11;
    grants = 0;
    cycles = 0;
    while (grants < 6 && cycles < 200) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) grants++;
      @(posedge clk);
      #1;
      cycles++;
    end
    req_valid = 2'b00;
    if (grants < 6) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL grant_timeout got %0d grants expected 6", grants);
    end

    cycles = 0;
    while ((rspQ.size() != 0 || accQ.size() != 0) && cycles < 100) begin
      @(posedge clk);
      cycles++;
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("rsp_queue_drained", rspQ.size(), 32'd0);
    checkOutput("acc_queue_drained", accQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
